vt_access_sequencer: RTL

- Controls one variable table cluster: drives its shared enable and write-enable, its per-table address bus and its common write data.
- Three requesters share the cluster:
  - init sweep: writes every variable address with zero or LFSR-random values;
  - flip engine: atomic read-invert-write of one variable, broadcast to all tables so they stay in sync;
  - evaluator read port: pass-through per-table reads.
- Fixed priority, highest first: init, flip, read.

---
 rtl/vt_access_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vt_access_sequencer.sv
// Access sequencer for one variable table cluster: arbitrates init sweep,
// atomic flip (read-invert-write broadcast) and evaluator reads onto the cluster bus.
module vt_access_sequencer #(
    parameter int          VARIABLE_ADDRESS_WIDTH = 11,
    parameter int          CLUSTER_SIZE           = 40,
    parameter logic [15:0] LFSR_SEED              = 16'hACE1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       init_start_i,
    input  logic                                       init_mode_i,
    input  logic [VARIABLE_ADDRESS_WIDTH-1:0]          num_vars_i,
    output logic                                       init_busy_o,
    output logic                                       init_done_o,
    input  logic                                       flip_valid_i,
    input  logic [VARIABLE_ADDRESS_WIDTH-1:0]          flip_addr_i,
    output logic                                       flip_ready_o,
    output logic                                       flip_done_o,
    output logic                                       flip_old_o,
    output logic                                       flip_err_o,
    input  logic                                       rd_req_i,
    input  logic [CLUSTER_SIZE*VARIABLE_ADDRESS_WIDTH-1:0] rd_addr_mi,
    output logic                                       rd_gnt_o,
    output logic                                       rd_valid_o,
    output logic [CLUSTER_SIZE-1:0]                    rd_data_mo,
    output logic                                       vt_en_o,
    output logic                                       vt_wr_en_o,
    output logic [CLUSTER_SIZE*VARIABLE_ADDRESS_WIDTH-1:0] vt_addr_mo,
    output logic                                       vt_data_o,
    input  logic [CLUSTER_SIZE-1:0]                    vt_data_mi
);

    localparam int W  = VARIABLE_ADDRESS_WIDTH;
    localparam int CS = CLUSTER_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INIT    = 2'd1,
        ST_FLIP_WR = 2'd2
    } state_t;

    // Fibonacci LFSR, taps 16/14/13/11, shifting left with feedback into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic all_equal(input logic [CLUSTER_SIZE-1:0] v);
        return (&v) | ~(|v);
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic           mode_r;
    logic [W-1:0]   num_vars_r;
    logic [W-1:0]   cnt_r;
    logic [15:0]    lfsr_r;
    logic [W-1:0]   flip_addr_r;
    logic           init_busy_r;
    logic           init_done_r;
    logic           flip_done_r;
    logic           flip_old_r;
    logic           flip_err_r;
    logic           rd_valid_r;
    logic           flip_ready_s;
    logic           rd_gnt_s;
    logic           vt_en_s;
    logic           vt_wr_en_s;
    logic [CS*W-1:0] vt_addr_s;
    logic           vt_data_s;

    // Arbitration, next state and cluster bus drive.
    always_comb begin
        state_next_s = state_r;
        flip_ready_s = 1'b0;
        rd_gnt_s     = 1'b0;
        vt_en_s      = 1'b0;
        vt_wr_en_s   = 1'b0;
        vt_addr_s    = {(CS*W){1'b0}};
        vt_data_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (init_start_i) begin
                    state_next_s = ST_INIT;
                end else if (flip_valid_i) begin
                    flip_ready_s = 1'b1;
                    vt_en_s      = 1'b1;
                    vt_addr_s    = {CS{flip_addr_i}};
                    state_next_s = ST_FLIP_WR;
                end else if (rd_req_i) begin
                    rd_gnt_s  = 1'b1;
                    vt_en_s   = 1'b1;
                    vt_addr_s = rd_addr_mi;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                vt_en_s    = 1'b1;
                vt_wr_en_s = 1'b1;
                vt_addr_s  = {CS{cnt_r}};
                // Address 0 is the literal-false slot and is always cleared.
                if (cnt_r == {W{1'b0}}) begin
                    vt_data_s = 1'b0;
                end else begin
                    vt_data_s = mode_r & lfsr_r[0];
                end
                if (cnt_r == num_vars_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_FLIP_WR: begin
                vt_en_s      = 1'b1;
                vt_wr_en_s   = 1'b1;
                vt_addr_s    = {CS{flip_addr_r}};
                vt_data_s    = ~vt_data_mi[0];
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, sweep counter, LFSR and latched request fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            mode_r      <= 1'b0;
            num_vars_r  <= {W{1'b0}};
            cnt_r       <= {W{1'b0}};
            lfsr_r      <= LFSR_SEED;
            flip_addr_r <= {W{1'b0}};
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (init_start_i) begin
                        mode_r     <= init_mode_i;
                        num_vars_r <= num_vars_i;
                        cnt_r      <= {W{1'b0}};
                        lfsr_r     <= LFSR_SEED;
                    end else if (flip_valid_i) begin
                        flip_addr_r <= flip_addr_i;
                    end
                end
                ST_INIT: begin
                    cnt_r  <= cnt_r + {{(W-1){1'b0}}, 1'b1};
                    lfsr_r <= lfsr_step(lfsr_r);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status outputs and completion pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_busy_r <= 1'b0;
            init_done_r <= 1'b0;
            flip_done_r <= 1'b0;
            flip_old_r  <= 1'b0;
            flip_err_r  <= 1'b0;
            rd_valid_r  <= 1'b0;
        end else begin
            init_busy_r <= (state_next_s == ST_INIT);
            init_done_r <= (state_r == ST_INIT) && (cnt_r == num_vars_r);
            flip_done_r <= (state_r == ST_FLIP_WR);
            rd_valid_r  <= rd_gnt_s;
            if (state_r == ST_FLIP_WR) begin
                flip_old_r <= vt_data_mi[0];
                flip_err_r <= ~all_equal(vt_data_mi);
            end else begin
                flip_err_r <= 1'b0;
            end
        end
    end

    assign init_busy_o  = init_busy_r;
    assign init_done_o  = init_done_r;
    assign flip_ready_o = flip_ready_s;
    assign flip_done_o  = flip_done_r;
    assign flip_old_o   = flip_old_r;
    assign flip_err_o   = flip_err_r;
    assign rd_gnt_o     = rd_gnt_s;
    assign rd_valid_o   = rd_valid_r;
    // Table outputs are already registered; gate them so data reads 0 outside valid.
    assign rd_data_mo   = {CS{rd_valid_r}} & vt_data_mi;
    assign vt_en_o      = vt_en_s;
    assign vt_wr_en_o   = vt_wr_en_s;
    assign vt_addr_mo   = vt_addr_s;
    assign vt_data_o    = vt_data_s;

endmodule
